// File: rtl/tug_game_ctrl.sv
// rtl/tug_game_ctrl.sv - tug-of-war game controller: human vs LFSR-driven CPU on a 9-LED playfield
module tug_game_ctrl #(
    parameter int HOLD_CYCLES = 8,
    parameter int WIN_SCORE   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_l,
    input  logic [8:0] difficulty,
    output logic [8:0] leds,
    output logic [2:0] score_l,
    output logic [2:0] score_r,
    output logic [1:0] winner,
    output logic       game_over
);

    localparam logic [1:0] ST_PLAY = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [2:0]      WIN_TGT   = 3'(WIN_SCORE);

    logic [1:0]    state, state_n;
    logic [3:0]    pos, pos_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [9:0]    lfsr;
    logic [2:0]    score_l_n, score_r_n;
    logic [1:0]    winner_n;
    logic [8:0]    leds_n;
    logic          cpu_press;
    logic          match_won;

    assign cpu_press = (state == ST_PLAY) && (lfsr[8:0] < difficulty);
    assign match_won = (winner == 2'b10 && score_l == WIN_TGT) ||
                       (winner == 2'b01 && score_r == WIN_TGT);

    always_comb begin
        state_n   = state;
        pos_n     = pos;
        hold_n    = hold_cnt;
        score_l_n = score_l;
        score_r_n = score_r;
        winner_n  = winner;
        case (state)
            ST_PLAY: begin
                // simultaneous presses cancel, so only a lone press moves the rope
                if (key_l && !cpu_press) begin
                    if (pos == 4'd8) begin
                        if (score_l < WIN_TGT) score_l_n = score_l + 3'd1;
                        winner_n = 2'b10;
                        hold_n   = '0;
                        state_n  = ST_HOLD;
                    end else begin
                        pos_n = pos + 4'd1;
                    end
                end else if (cpu_press && !key_l) begin
                    if (pos == 4'd0) begin
                        if (score_r < WIN_TGT) score_r_n = score_r + 3'd1;
                        winner_n = 2'b01;
                        hold_n   = '0;
                        state_n  = ST_HOLD;
                    end else begin
                        pos_n = pos - 4'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    if (match_won) begin
                        state_n = ST_OVER;
                    end else begin
                        pos_n    = 4'd4;
                        winner_n = 2'b00;
                        state_n  = ST_PLAY;
                    end
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            ST_OVER: begin
            end
            default: begin
                state_n  = ST_PLAY;
                pos_n    = 4'd4;
                winner_n = 2'b00;
                hold_n   = '0;
            end
        endcase
        leds_n = (state_n == ST_OVER) ? 9'd0 : (9'd1 << pos_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_PLAY;
            pos       <= 4'd4;
            hold_cnt  <= '0;
            lfsr      <= 10'h001;
            score_l   <= 3'd0;
            score_r   <= 3'd0;
            winner    <= 2'b00;
            leds      <= 9'b000010000;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            pos       <= pos_n;
            hold_cnt  <= hold_n;
            lfsr      <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            score_l   <= score_l_n;
            score_r   <= score_r_n;
            winner    <= winner_n;
            leds      <= leds_n;
            game_over <= (state_n == ST_OVER);
        end
    end

endmodule
